// File: rtl/param_serializer.sv
// Parallel-to-serial shifter with configurable width, bit order and bit period.
// Define PS_PARITY_EN to append an even-parity bit to every frame.
module param_serializer #(
    parameter int WIDTH        = 8,
    parameter int MSB_FIRST    = 0,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] p_data,
    output logic             in_ready,
    output logic             s_data,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int CCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CCW-1:0] CYC_LAST     = CCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] BIT_LAST     = BCW'(WIDTH);
    localparam logic [BCW-1:0] BIT_PRE_LAST = BCW'(WIDTH - 1);

`ifdef PS_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    function automatic logic first_bit(input logic [WIDTH-1:0] word);
        if (MSB_FIRST != 0) begin
            first_bit = word[WIDTH-1];
        end else begin
            first_bit = word[0];
        end
    endfunction

    // Drops the bit just emitted so the next one sits at the output end.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] word);
        if (MSB_FIRST != 0) begin
            shift_out = {word[WIDTH-2:0], 1'b0};
        end else begin
            shift_out = {1'b0, word[WIDTH-1:1]};
        end
    endfunction

`ifdef PS_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        even_parity = ^word;
    endfunction
`endif

    state_t           r_state,    w_state;
    logic [WIDTH-1:0] r_shift,    w_shift;
    logic [BCW-1:0]   r_bit_cnt,  w_bit_cnt;
    logic [CCW-1:0]   r_cyc_cnt,  w_cyc_cnt;
    logic             r_s_data,   w_s_data;
    logic             r_s_valid,  w_s_valid;
    logic             r_s_last,   w_s_last;
    logic             r_in_ready, w_in_ready;
`ifdef PS_PARITY_EN
    logic             r_parity,   w_parity;
`endif
    logic             w_accept;
    logic             w_bit_end;

    assign w_accept  = in_valid && r_in_ready;
    assign w_bit_end = (r_cyc_cnt == CYC_LAST);

    // Next-state and next-output decode; in_ready is only ever high when a new word may load.
    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_bit_cnt = r_bit_cnt;
        w_cyc_cnt = r_cyc_cnt;
        w_s_data  = r_s_data;
        w_s_valid = r_s_valid;
        w_s_last  = r_s_last;
`ifdef PS_PARITY_EN
        w_parity  = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_s_data  = 1'b0;
                w_s_valid = 1'b0;
                w_s_last  = 1'b0;
            end
            ST_SHIFT: begin
                if (!w_bit_end) begin
                    w_cyc_cnt = r_cyc_cnt + CCW'(1);
                end else if (r_bit_cnt != BIT_LAST) begin
                    w_s_data  = first_bit(r_shift);
                    w_shift   = shift_out(r_shift);
                    w_bit_cnt = r_bit_cnt + BCW'(1);
                    w_cyc_cnt = {CCW{1'b0}};
`ifdef PS_PARITY_EN
                    w_s_last  = 1'b0;
`else
                    w_s_last  = (r_bit_cnt == BIT_PRE_LAST);
`endif
                end else begin
`ifdef PS_PARITY_EN
                    w_state   = ST_PARITY;
                    w_s_data  = r_parity;
                    w_s_last  = 1'b1;
                    w_cyc_cnt = {CCW{1'b0}};
`else
                    w_state   = ST_IDLE;
                    w_shift   = {WIDTH{1'b0}};
                    w_bit_cnt = {BCW{1'b0}};
                    w_cyc_cnt = {CCW{1'b0}};
                    w_s_data  = 1'b0;
                    w_s_valid = 1'b0;
                    w_s_last  = 1'b0;
`endif
                end
            end
`ifdef PS_PARITY_EN
            ST_PARITY: begin
                if (!w_bit_end) begin
                    w_cyc_cnt = r_cyc_cnt + CCW'(1);
                end else begin
                    w_state   = ST_IDLE;
                    w_shift   = {WIDTH{1'b0}};
                    w_bit_cnt = {BCW{1'b0}};
                    w_cyc_cnt = {CCW{1'b0}};
                    w_parity  = 1'b0;
                    w_s_data  = 1'b0;
                    w_s_valid = 1'b0;
                    w_s_last  = 1'b0;
                end
            end
`endif
            default: begin
                w_state   = ST_IDLE;
                w_shift   = {WIDTH{1'b0}};
                w_bit_cnt = {BCW{1'b0}};
                w_cyc_cnt = {CCW{1'b0}};
                w_s_data  = 1'b0;
                w_s_valid = 1'b0;
                w_s_last  = 1'b0;
            end
        endcase

        // An accept can only happen in IDLE or the final cycle of a frame, so it always starts a new frame.
        if (w_accept) begin
            w_state   = ST_SHIFT;
            w_s_data  = first_bit(p_data);
            w_shift   = shift_out(p_data);
            w_bit_cnt = BCW'(1);
            w_cyc_cnt = {CCW{1'b0}};
            w_s_valid = 1'b1;
            w_s_last  = 1'b0;
`ifdef PS_PARITY_EN
            w_parity  = even_parity(p_data);
`endif
        end else begin
            w_s_valid = w_s_valid;
        end

        if (w_state == ST_IDLE) begin
            w_in_ready = 1'b1;
        end else begin
            w_in_ready = w_s_last && (w_cyc_cnt == CYC_LAST);
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= {WIDTH{1'b0}};
            r_bit_cnt  <= {BCW{1'b0}};
            r_cyc_cnt  <= {CCW{1'b0}};
            r_s_data   <= 1'b0;
            r_s_valid  <= 1'b0;
            r_s_last   <= 1'b0;
            r_in_ready <= 1'b1;
`ifdef PS_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_bit_cnt  <= w_bit_cnt;
            r_cyc_cnt  <= w_cyc_cnt;
            r_s_data   <= w_s_data;
            r_s_valid  <= w_s_valid;
            r_s_last   <= w_s_last;
            r_in_ready <= w_in_ready;
`ifdef PS_PARITY_EN
            r_parity   <= w_parity;
`endif
        end
    end

    assign in_ready = r_in_ready;
    assign s_data   = r_s_data;
    assign s_valid  = r_s_valid;
    assign s_last   = r_s_last;
    assign busy     = r_s_valid;

endmodule

// File: tb/tb_param_serializer.sv
// Directed bench for param_serializer: LSB-first CLKS_PER_BIT=1 instance and an
// MSB-first CLKS_PER_BIT=3 instance; expectations follow PS_PARITY_EN when defined.
module tb_param_serializer;

`ifdef PS_PARITY_EN
    localparam int FLEN = 9;
    localparam logic [8:0] SEQ_96     = 9'b011010010;
    localparam logic [8:0] SEQ_A7     = 9'b111001011;
    localparam logic [8:0] SEQ_0F     = 9'b111100000;
    localparam logic [8:0] SEQ_96_MSB = 9'b100101100;
`else
    localparam int FLEN = 8;
    localparam logic [8:0] SEQ_96     = 9'b001101001;
    localparam logic [8:0] SEQ_A7     = 9'b011100101;
    localparam logic [8:0] SEQ_0F     = 9'b011110000;
    localparam logic [8:0] SEQ_96_MSB = 9'b010010110;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic       a_ready, a_sd, a_sv, a_sl, a_busy;
    logic       b_ready, b_sd, b_sv, b_sl, b_busy;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    param_serializer #(.WIDTH(8), .MSB_FIRST(0), .CLKS_PER_BIT(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .p_data(a_data), .in_ready(a_ready),
        .s_data(a_sd), .s_valid(a_sv), .s_last(a_sl), .busy(a_busy)
    );

    param_serializer #(.WIDTH(8), .MSB_FIRST(1), .CLKS_PER_BIT(3)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .p_data(b_data), .in_ready(b_ready),
        .s_data(b_sd), .s_valid(b_sv), .s_last(b_sl), .busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle_a(input string tag);
        check_eq({tag, "_sv"},    a_sv,    1'b0);
        check_eq({tag, "_sd"},    a_sd,    1'b0);
        check_eq({tag, "_sl"},    a_sl,    1'b0);
        check_eq({tag, "_busy"},  a_busy,  1'b0);
        check_eq({tag, "_ready"}, a_ready, 1'b1);
    endtask

    // One frame on instance A; the accept edge is the posedge before the first loop cycle.
    task automatic run_a(input logic [8:0] seq, input string tag, input logic keep_valid,
                         input logic [7:0] next_word, input logic pulse_mid);
        for (int c = 0; c < FLEN; c++) begin
            @(negedge clk);
            check_eq($sformatf("%s_c%0d_sv", tag, c),    a_sv,    1'b1);
            check_eq($sformatf("%s_c%0d_busy", tag, c),  a_busy,  1'b1);
            check_eq($sformatf("%s_c%0d_sd", tag, c),    a_sd,    seq[FLEN-1-c]);
            check_eq($sformatf("%s_c%0d_sl", tag, c),    a_sl,    (c == FLEN-1));
            check_eq($sformatf("%s_c%0d_ready", tag, c), a_ready, (c == FLEN-1));
            if (c == 0) begin
                if (keep_valid) a_data = next_word;
                else            a_valid = 1'b0;
            end
            if (pulse_mid && c == 3) begin
                a_valid = 1'b1;
                a_data  = 8'h55;
            end
            if (pulse_mid && c == 4) a_valid = 1'b0;
        end
    endtask

    initial begin
        rst     = 1'b1;
        a_valid = 1'b0;
        a_data  = 8'h00;
        b_valid = 1'b0;
        b_data  = 8'h00;

        @(negedge clk);
        check_idle_a("rst");
        check_eq("rst_b_ready", b_ready, 1'b1);
        check_eq("rst_b_sv", b_sv, 1'b0);

        // Accept on the very first edge after reset release.
        rst     = 1'b0;
        a_valid = 1'b1;
        a_data  = 8'h96;
        run_a(SEQ_96, "lsb96", 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_idle_a("idle1");

        a_valid = 1'b1;
        a_data  = 8'hA7;
        run_a(SEQ_A7, "lsbA7", 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_idle_a("idle2");

        // Back-to-back frames with in_valid held high.
        a_valid = 1'b1;
        a_data  = 8'h96;
        run_a(SEQ_96, "b2b1", 1'b1, 8'h0F, 1'b0);
        run_a(SEQ_0F, "b2b2", 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check_idle_a("idle3");

        // Mid-frame in_valid pulse must be ignored.
        a_valid = 1'b1;
        a_data  = 8'h96;
        run_a(SEQ_96, "pulse", 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check_idle_a("idle4a");
        @(negedge clk);
        check_idle_a("idle4b");

        // Asynchronous reset in cycle 4 of a frame.
        a_valid = 1'b1;
        a_data  = 8'h96;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("prerst_c%0d_sd", c), a_sd, SEQ_96[FLEN-1-c]);
            if (c == 0) a_valid = 1'b0;
        end
        #1 rst = 1'b1;
        #1 check_idle_a("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_idle_a($sformatf("postrst%0d", c));
        end

        // MSB-first, three cycles per bit.
        b_valid = 1'b1;
        b_data  = 8'h96;
        for (int c = 0; c < FLEN*3; c++) begin
            @(negedge clk);
            check_eq($sformatf("msb_c%0d_sv", c),    b_sv,    1'b1);
            check_eq($sformatf("msb_c%0d_sd", c),    b_sd,    SEQ_96_MSB[FLEN-1-(c/3)]);
            check_eq($sformatf("msb_c%0d_sl", c),    b_sl,    (c >= FLEN*3-3));
            check_eq($sformatf("msb_c%0d_ready", c), b_ready, (c == FLEN*3-1));
            if (c == 0) b_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("msb_end_sv", b_sv, 1'b0);
        check_eq("msb_end_busy", b_busy, 1'b0);
        check_eq("msb_end_ready", b_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
